// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding, slice width and counter sizing
// for the nibble-serial adder.
package nibble_serial_adder_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_w(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// nibble_add4: combinational 4-bit adder slice; c3 is the carry into bit 3,
// which the top needs to derive two's-complement overflow.
module nibble_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3
);

   logic [3:0] lo;

   assign lo      = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
   assign c3      = lo[3];
   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that processes one nibble per clock, LSB first,
// through a single 4-bit slice with a registered carry, behind valid/ready handshakes.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int CNT_W   = cnt_w(NIBBLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             c3_q, c3_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       s4;
   logic             co4;
   logic             c34;
   logic             last;

   nibble_add4 u_slice (
      .a (a_q[3:0]),
      .b (b_q[3:0]),
      .ci(carry_q),
      .s (s4),
      .co(co4),
      .c3(c34)
   );

   assign last      = cnt_q == CNT_W'(NIBBLES - 1);
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign sum       = res_q;
   assign cout      = carry_q;
   assign ovf       = c3_q ^ carry_q;

   // Result fills from the top so the first (LSB) nibble ends up at bit 0 after NIBBLES shifts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      c3_d    = c3_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      if (state_q == IDLE && in_valid) begin
         state_d = RUN;
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         res_d   = (res_q >> NIB_W) | (WIDTH'(s4) << (WIDTH - NIB_W));
         a_d     = a_q >> NIB_W;
         b_d     = b_q >> NIB_W;
         carry_d = co4;
         cnt_d   = last ? cnt_q : cnt_q + CNT_W'(1);
         c3_d    = last ? c34 : c3_q;
         state_d = last ? DONE : RUN;
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c3_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         c3_q    <= c3_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that adds two WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first.
- Each step uses one 4-bit carry-ripple slice; the slice's carry-out is registered and fed back as the next nibble's carry-in.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area when datapaths are wider than 4 bits.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per operation.
- CNT_W, max(1, clog2(NIBBLES)), derived localparam; nibble counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands a, b, cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into nibble 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  out  1  carry out of MSB.
- ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On a clk edge with rst=1: state=IDLE, counter=0, carry reg=0, operand shift regs=0.
  - Outputs after that edge: sum=0, cout=0, ovf=0, out_valid=0.
  - rst overrides every other event on that edge.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), combinational from state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept on an edge with in_valid && in_ready.
  - Capture a and b into shift regs, cin into the carry reg, and clear the counter.
  - Go to RUN. With no accept, stay in IDLE.
- RUN (one nibble per cycle):
  - Slice inputs: A nibble = a_sh[3:0], B nibble = b_sh[3:0], carry-in = carry reg.
  - Each edge:
    - Shift the slice's sum nibble into the result reg from the top (result = {s4, result[WIDTH-1:4]}).
    - Shift a_sh and b_sh right by 4.
    - carry reg <= slice cout.
    - On the last nibble (counter==NIBBLES-1), also latch the slice's internal carry into bit 3 as c_msb_in.
  - After NIBBLES edges go to DONE.
  - in_valid is ignored in RUN; in_ready=0 there.
- DONE:
  - sum = result reg, cout = carry reg, ovf = c_msb_in XOR carry reg.
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1: go to IDLE. sum, cout and ovf keep their values, but are meaningful only while out_valid=1.
- Latency: accept edge T0 -> out_valid=1 from edge T0+NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles minimum; no overlap of accept and drain.
- NIBBLES=1 (WIDTH=4) is legal: exactly one RUN cycle.
- Counter wraps to 0 only via a new accept; it never advances outside RUN.
- Reset mid-RUN or mid-DONE: the operation is discarded with no partial result and no out_valid pulse. in_ready=1 in the cycle after the reset edge if rst has deasserted.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is valid for signed interpretation only; consumers ignore it otherwise.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the nibble-width constant 4;
  - a function computing CNT_W.
- One sub-module: nibble_add4, a purely combinational 4-bit slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, c3, where c3 is the carry into bit 3 and is needed for ovf.
- FSM, counter, shift registers and handshake logic all live in the top module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, confirming carry propagation across all 4 nibbles. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: complete an op, hold out_ready=0 for 6 cycles -> out_valid, sum, cout and ovf stable and in_ready=0 throughout. Raise out_ready -> IDLE next edge, then in_ready=1. Toggle in_valid with a new operand during RUN -> no second capture and no change to the result.
- Reset mid-RUN: accept 0x1111+0x2222, assert rst for 1 cycle on the 2nd RUN edge -> out_valid never asserts for that op, and all outputs are 0 after the reset edge. Then 0x0003+0x0004 -> sum=0x0007.
- Back-to-back with in_valid held high and out_ready=1: 3 ops accepted, spaced exactly NIBBLES+2=6 cycles apart, with results in order. Random regression of 1000 ops at WIDTH=4, 16 and 32 against a reference model with random out_ready.
